// File: rtl/conv_layer_ctrl_pkg.sv
// Shared definitions for the convolution layer sequencer.
//   BYTE         : width of channel / bias indices
//   OUT_ADDR_W   : default output address width
//   ctrl_state_e : sequencer state encoding (3 bits)
//   conv_total() : number of output pixels in one layer
package conv_layer_ctrl_pkg;

    localparam int unsigned BYTE       = 8;
    localparam int unsigned OUT_ADDR_W = 16;

    typedef enum logic [2:0] {
        CtrlIdle  = 3'd0,
        CtrlInit  = 3'd1,
        CtrlPrime = 3'd2,
        CtrlRun   = 3'd3,
        CtrlWrite = 3'd4,
        CtrlLast  = 3'd5,
        CtrlDone  = 3'd6
    } ctrl_state_e;

    function automatic int unsigned conv_total(input int unsigned ch, input int unsigned dim);
        return ch * dim * dim;
    endfunction

endpackage

// File: rtl/conv_layer_ctrl_if.sv
// Sequencer <-> iterator/accumulator/output-buffer bundle.
//   master (sequencer): drives it_reset, en_ctrl, acc_init, bias_addr, wr_en, wr_addr;
//                       samples en_save, fin_r, i, out_ready.
//   slave  (datapath) : the reverse.
interface conv_layer_ctrl_if
    import conv_layer_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = OUT_ADDR_W
) ();

    logic              it_reset;
    logic              en_ctrl;
    logic              en_save;
    logic              fin_r;
    logic [BYTE-1:0]   i;
    logic              acc_init;
    logic [BYTE-1:0]   bias_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              out_ready;

    modport master (
        output it_reset, en_ctrl, acc_init, bias_addr, wr_en, wr_addr,
        input  en_save, fin_r, i, out_ready
    );

    modport slave (
        input  it_reset, en_ctrl, acc_init, bias_addr, wr_en, wr_addr,
        output en_save, fin_r, i, out_ready
    );

endinterface

// File: rtl/conv_layer_ctrl_edge_rise.sv
// Registered rising-edge detector with sample enable.
//   clk, reset : clock, synchronous active-high reset
//   en         : the history register only samples d while en is high
//   d          : level input
//   rise       : d high while the last sampled value was low (combinational)
module conv_layer_ctrl_edge_rise (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic d,
    output logic rise
);

    logic d_q, d_d;

    always_comb begin
        d_d = d_q;
        if (en) begin
            d_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/conv_layer_ctrl.sv
// Convolution layer sequencer.
//   clk, reset        : clock, synchronous active-high reset
//   start             : layer start request (accepted in IDLE only)
//   busy              : layer in progress (cycle after start through DONE)
//   done              : one-cycle end-of-layer pulse
//   cnt_err           : sticky, write count differed from the expected pixel total
//   dp (master)       : iterator gating, accumulator preload and output write port
module conv_layer_ctrl
    import conv_layer_ctrl_pkg::*;
#(
    parameter int unsigned CONV_OUT_CH  = 32,
    parameter int unsigned CONV_DIM_OUT = 32,
    parameter int unsigned ADDR_W       = OUT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              cnt_err,
    conv_layer_ctrl_if.master dp
);

    localparam logic [ADDR_W-1:0] Total = ADDR_W'(conv_total(CONV_OUT_CH, CONV_DIM_OUT));

    ctrl_state_e       state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              cnt_err_q, cnt_err_d;
    logic              first_q, first_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              en_ctrl_q, en_ctrl_d;
    logic              wr_en_q, wr_en_d;
    logic              prime_q, prime_d;
    logic              sv_rise;

    // save history only moves while the iterator is advancing
    conv_layer_ctrl_edge_rise u_sv_rise (
        .clk   (clk),
        .reset (reset),
        .en    (en_ctrl_q),
        .d     (dp.en_save),
        .rise  (sv_rise)
    );

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        cnt_err_d = cnt_err_q;
        first_d   = first_q;
        unique case (state_q)
            CtrlIdle: begin
                if (start) begin
                    state_d   = CtrlInit;
                    wr_addr_d = '0;
                    cnt_err_d = 1'b0;
                    first_d   = 1'b1;
                end
            end
            CtrlInit:  state_d = CtrlPrime;
            CtrlPrime: state_d = CtrlRun;
            CtrlRun: begin
                if (dp.fin_r) begin
                    state_d = CtrlLast;
                end else if (sv_rise) begin
                    // first boundary opens window 0: nothing accumulated yet
                    if (first_q) begin
                        first_d = 1'b0;
                    end else begin
                        state_d = CtrlWrite;
                    end
                end
            end
            CtrlWrite: begin
                if (dp.out_ready) begin
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                    state_d   = CtrlRun;
                end
            end
            CtrlLast: begin
                if (dp.out_ready) begin
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                    state_d   = CtrlDone;
                    // judged on the final count so the flag is already valid in DONE
                    cnt_err_d = (wr_addr_q + ADDR_W'(1)) != Total;
                end
            end
            CtrlDone: state_d = CtrlIdle;
            default:  state_d = CtrlIdle;
        endcase

        busy_d    = state_d != CtrlIdle;
        done_d    = state_d == CtrlDone;
        en_ctrl_d = state_d == CtrlRun;
        wr_en_d   = (state_d == CtrlWrite) || (state_d == CtrlLast);
        prime_d   = state_d == CtrlPrime;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CtrlIdle;
            wr_addr_q <= '0;
            cnt_err_q <= 1'b0;
            first_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            en_ctrl_q <= 1'b0;
            wr_en_q   <= 1'b0;
            prime_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            cnt_err_q <= cnt_err_d;
            first_q   <= first_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            en_ctrl_q <= en_ctrl_d;
            wr_en_q   <= wr_en_d;
            prime_q   <= prime_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign cnt_err = cnt_err_q;

    assign dp.it_reset  = reset | (state_q == CtrlInit);
    assign dp.en_ctrl   = en_ctrl_q;
    assign dp.wr_en     = wr_en_q;
    assign dp.wr_addr   = wr_addr_q;
    assign dp.bias_addr = dp.i;
    // the next window's bias is loaded in the very cycle the previous result is accepted
    assign dp.acc_init  = prime_q | ((state_q == CtrlWrite) & dp.out_ready);

endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Self-checking bench for conv_layer_ctrl with a behavioural iterator model.
module tb_conv_layer_ctrl;
    import conv_layer_ctrl_pkg::*;

    localparam int unsigned CH     = 2;
    localparam int unsigned DIM    = 2;
    localparam int unsigned ADDR_W = 16;
    localparam int          PIX    = DIM * DIM;
    localparam int          TOTAL  = CH * DIM * DIM;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy, done, cnt_err;

    conv_layer_ctrl_if #(.ADDR_W(ADDR_W)) dp_if ();

    conv_layer_ctrl #(
        .CONV_OUT_CH  (CH),
        .CONV_DIM_OUT (DIM),
        .ADDR_W       (ADDR_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .cnt_err (cnt_err),
        .dp      (dp_if)
    );

    always #5 clk = ~clk;

    // Iterator model: counts enabled cycles; windows are win_len cycles long,
    // en_save high on the first cycle of each window, fin_r once win_n windows elapsed.
    int cyc     = 0;
    int win_n   = 8;
    int win_len = 3;

    always @(posedge clk) begin
        if (dp_if.it_reset) cyc <= 0;
        else if (dp_if.en_ctrl) cyc <= cyc + 1;
    end

    assign dp_if.en_save = (cyc < win_n * win_len) && ((cyc % win_len) == 0);
    assign dp_if.fin_r   = cyc >= win_n * win_len;
    assign dp_if.i       = BYTE'((cyc / win_len) / PIX);

    // Scoreboard
    int nchk  = 0;
    int nfail = 0;
    int wr_q[$];
    int acc_q[$];
    int viol, done_n, hold2, stall_left, stall_addr;
    logic err_at_done;

    always @(negedge clk) begin
        if (!reset) begin
            if (dp_if.wr_en && dp_if.out_ready) wr_q.push_back(int'(dp_if.wr_addr));
            if (dp_if.acc_init) acc_q.push_back(int'(dp_if.bias_addr));
            if (dp_if.wr_en && dp_if.en_ctrl) viol++;
            if (dp_if.wr_en && dp_if.wr_addr == ADDR_W'(2)) hold2++;
            if (done) begin
                done_n++;
                err_at_done = cnt_err;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic sb_clear();
        wr_q.delete();
        acc_q.delete();
        viol = 0; done_n = 0; hold2 = 0; err_at_done = 1'bx;
    endtask

    task automatic check_sb(input int nw);
        int bad_w, bad_a;
        bad_w = 0;
        bad_a = 0;
        for (int k = 0; k < nw; k++) begin
            if (k >= wr_q.size() || wr_q[k] != k) bad_w++;
            // acc entry k preloads window k: channel is the window index over pixels/channel
            if (k >= acc_q.size() || acc_q[k] != k / PIX) bad_a++;
        end
        check("wr_count", wr_q.size(), nw);
        check("wr_addr_seq", bad_w, 0);
        check("acc_count", acc_q.size(), nw);
        check("bias_seq", bad_a, 0);
        check("done_pulses", done_n, 1);
        check("cnt_err_at_done", err_at_done, (nw != TOTAL) ? 1 : 0);
        check("en_ctrl_during_write", viol, 0);
    endtask

    task automatic wait_done(input int rdy_pct, input bit poke);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 3000 && !ok; n++) begin
            next_cycle();
            if (stall_left > 0 && dp_if.wr_en && dp_if.wr_addr == ADDR_W'(stall_addr)) begin
                dp_if.out_ready = 1'b0;
                stall_left--;
            end else begin
                dp_if.out_ready = ($urandom_range(99) < rdy_pct);
            end
            start = poke && busy;
            #1;
            if (done) ok = 1'b1;
        end
        start = 1'b0;
        dp_if.out_ready = 1'b1;
        check("done_seen", ok, 1);
        for (int n = 0; n < 3; n++) begin
            next_cycle();
            #1;
            check("idle_after_done", {busy, dp_if.en_ctrl, dp_if.wr_en, done}, 0);
        end
    endtask

    task automatic run_layer(input int nw, input int len, input int rdy_pct, input bit poke);
        win_n = nw;
        win_len = len;
        sb_clear();
        next_cycle();
        start = 1'b1;
        dp_if.out_ready = 1'b1;
        next_cycle();
        start = 1'b0;
        #1;
        check("init_it_reset", dp_if.it_reset, 1);
        check("init_cnt_err_clear", cnt_err, 0);
        wait_done(rdy_pct, poke);
    endtask

    typedef struct {
        bit         st;
        bit         rdy;
        logic [5:0] exp; // {busy, it_reset, acc_init, en_ctrl, wr_en, done}
    } vec_t;

    vec_t vecs[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset = 1'b1;
        start = 1'b0;
        dp_if.out_ready = 1'b1;
        stall_left = 0;
        stall_addr = 0;
        sb_clear();

        repeat (3) next_cycle();
        #1;
        check("reset_outputs", {busy, done, cnt_err, dp_if.en_ctrl, dp_if.wr_en,
                                dp_if.acc_init, dp_if.wr_addr}, 0);
        check("reset_it_reset", dp_if.it_reset, 1);
        reset = 1'b0;
        #1;
        check("idle_it_reset", dp_if.it_reset, 0);

        // Start-up timing and first windows, then full layer with out_ready=1
        vecs[0] = '{1'b1, 1'b1, 6'b000000};
        vecs[1] = '{1'b0, 1'b1, 6'b110000};
        vecs[2] = '{1'b0, 1'b1, 6'b101000};
        vecs[3] = '{1'b0, 1'b1, 6'b100100};
        vecs[4] = '{1'b0, 1'b1, 6'b100100};
        vecs[5] = '{1'b0, 1'b1, 6'b100100};
        vecs[6] = '{1'b0, 1'b1, 6'b100100};
        vecs[7] = '{1'b0, 1'b1, 6'b101010};
        vecs[8] = '{1'b0, 1'b1, 6'b100100};
        win_n = 8;
        win_len = 3;
        sb_clear();
        next_cycle();
        for (int k = 0; k < 9; k++) begin
            start = vecs[k].st;
            dp_if.out_ready = vecs[k].rdy;
            #1;
            check($sformatf("timing_c%0d", k), {busy, dp_if.it_reset, dp_if.acc_init,
                  dp_if.en_ctrl, dp_if.wr_en, done}, vecs[k].exp);
            if (vecs[k].exp[3]) check($sformatf("bias_c%0d", k), dp_if.bias_addr, 0);
            next_cycle();
        end
        start = 1'b0;
        wait_done(100, 1'b0);
        check_sb(8);
        check("cnt_err_idle_ok", cnt_err, 0);

        // Stall the third write for five cycles
        stall_addr = 2;
        stall_left = 5;
        run_layer(8, 3, 100, 1'b0);
        check_sb(8);
        check("stall_hold_cycles", hold2, 6);

        // Short layer flags a count error, next start clears it
        run_layer(5, 3, 100, 1'b0);
        check_sb(5);
        check("cnt_err_sticky", cnt_err, 1);
        run_layer(8, 2, 100, 1'b0);
        check_sb(8);

        // Reset while held in WRITE
        win_n = 8;
        win_len = 3;
        dp_if.out_ready = 1'b0;
        next_cycle();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            next_cycle();
            #1;
            if (dp_if.wr_en) found = 1'b1;
        end
        check("reached_write", found, 1);
        reset = 1'b1;
        #1;
        check("reset_it_reset_comb", dp_if.it_reset, 1);
        next_cycle();
        #1;
        check("mid_reset_outputs", {busy, done, cnt_err, dp_if.en_ctrl, dp_if.wr_en,
                                    dp_if.acc_init, dp_if.wr_addr}, 0);
        reset = 1'b0;
        dp_if.out_ready = 1'b1;
        #1;
        check("post_reset_it_reset", dp_if.it_reset, 0);
        run_layer(8, 3, 100, 1'b0);
        check_sb(8);

        // start held high while busy and in DONE must be ignored
        run_layer(8, 2, 100, 1'b1);
        check_sb(8);

        // Randomised layers
        for (int r = 0; r < 6; r++) begin
            int nw, len, pct;
            nw  = $urandom_range(8, 3);
            len = $urandom_range(5, 2);
            pct = $urandom_range(100, 40);
            run_layer(nw, len, pct, 1'($urandom_range(1)));
            check_sb(nw);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
